// File: rtl/serv_pc_seq.sv
// Beat sequencer for the bit-serial PC path: fetch handshake, run-beat counter
// and the beat-position strobes consumed by serv_ctrl.
module serv_pc_seq #(
  parameter int W = 1
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_ibus_ack,
  input  logic       i_go,
  input  logic       i_stall,
  output logic       o_ibus_cyc,
  output logic       o_pc_en,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_cnt2,
  output logic       o_cnt3,
  output logic       o_cnt03,
  output logic       o_cnt8,
  output logic       o_cnt12to31,
  output logic       o_cnt_done,
  output logic [4:0] o_pos
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    RUN   = 2'd3
  } state_e;

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  state_e     state_q;
  logic [4:0] pos_q;
  logic       run;

  // The position wraps through the 5-bit add, so it is already 0 on FETCH entry.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (i_ibus_ack) state_q <= WAIT;
        WAIT: begin
          if (i_go) begin
            state_q <= RUN;
            pos_q   <= '0;
          end
        end
        RUN: begin
          if (!i_stall) begin
            pos_q <= pos_q + STEP;
            if (pos_q == LAST) state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run         = (state_q == RUN);
  assign o_ibus_cyc  = (state_q == FETCH);
  assign o_pc_en     = run && !i_stall;
  assign o_cnt0      = run && (pos_q == 5'd0);
  assign o_cnt1      = run && (pos_q == 5'd1);
  assign o_cnt2      = run && (pos_q == 5'd2);
  assign o_cnt3      = run && (pos_q == 5'd3);
  assign o_cnt03     = run && (pos_q < 5'd4);
  assign o_cnt8      = run && (pos_q == 5'd8);
  assign o_cnt12to31 = run && (pos_q >= 5'd12);
  assign o_cnt_done  = run && (pos_q == LAST);
  assign o_pos       = run ? pos_q : 5'd0;

endmodule

// File: doc/serv_pc_seq.md
# serv_pc_seq

Bit-serial sequencer that drives the PC/control datapath (`serv_ctrl`) and the instruction bus fetch handshake. It walks the PC through 32/W beats per instruction and generates the beat-position strobes `serv_ctrl` consumes: `cnt0`, `cnt1`, `cnt2`, `cnt3`, `cnt03`, `cnt8`, `cnt12to31` and `pc_en`. It then issues the next fetch. It sits between the decoder/register-file ready logic and `serv_ctrl`, and owns `o_ibus_cyc`.

## Interface
- `W`, default 1: datapath width in bits per beat. Legal values are 1, 4, 8. Beats per instruction = 32/W.
- `clk`, input, 1: clock. All logic updates on the rising edge.
- `i_rst_n`, input, 1: reset. Synchronous, active-low.
- `i_ibus_ack`, input, 1: instruction bus acknowledge. Sampled only in FETCH.
- `i_go`, input, 1: decoder and register file are ready to execute. Sampled only in WAIT.
- `i_stall`, input, 1: freezes the beat counter during RUN.
- `o_ibus_cyc`, output, 1: instruction fetch request.
- `o_pc_en`, output, 1: PC shift enable to `serv_ctrl`.
- `o_cnt0`, `o_cnt1`, `o_cnt2`, `o_cnt3`, `o_cnt03`, `o_cnt8`, `o_cnt12to31`, output, 1 each: beat-position strobes.
- `o_cnt_done`, output, 1: the current beat is the last beat.
- `o_pos`, output, 5: current bit position p.

## Operation
- States: IDLE, FETCH, WAIT, RUN. State is registered. All outputs decode combinationally from the registered state and p; there are no input-to-output combinational paths except `o_pc_en`.
- Reset (`i_rst_n`=0 at an edge) sends the state to IDLE and p to 0. Reset takes effect from any state, including mid-RUN. A partial PC shift is abandoned; `serv_ctrl` reloads RESET_PC on its own reset.
- IDLE always moves to FETCH on the next edge. IDLE ignores `i_ibus_ack`, `i_go` and `i_stall`.
- FETCH:
  - `o_ibus_cyc`=1.
  - With `i_ibus_ack`=1, move to WAIT. `o_ibus_cyc` is 0 from the next cycle.
  - Without ack, remain in FETCH indefinitely.
- WAIT:
  - With `i_go`=1, move to RUN with p=0.
  - Otherwise hold.
  - An ack seen in WAIT is ignored.
- RUN:
  - `o_pc_en` = !`i_stall`.
  - When `i_stall`=0, p advances by W at the edge.
  - When `i_stall`=1, p and all strobes hold their values.
- Strobes are 0 outside RUN. In RUN:
  - `cnt0` = (p==0)
  - `cnt1` = (p==1)
  - `cnt2` = (p==2)
  - `cnt3` = (p==3)
  - `cnt03` = (p<4)
  - `cnt8` = (p==8)
  - `cnt12to31` = (p>=12)
  - `cnt_done` = (p==32−W)
- Consequence for W=4: `cnt1`, `cnt2` and `cnt3` are never high. For W=8, beats sit at p = 0, 8, 16, 24.
- Last beat: when `cnt_done`=1 and `i_stall`=0, the next state is FETCH and p wraps to 0 (5-bit modular add, no carry kept).
- Stall on the last beat holds RUN. FETCH is entered only after an unstalled last beat.
- `o_pos` reads 0 outside RUN.

## Timing
- Reset values: state IDLE, p=0, `o_ibus_cyc`=0, `o_pc_en`=0, all strobes 0, `o_pos`=0.
- First `o_ibus_cyc` rises in the 2nd cycle after the first edge with `i_rst_n`=1.
- Ack in cycle n gives WAIT in cycle n+1. The earliest `i_go` is in n+1, giving RUN beat 0 in n+2.
- RUN lasts exactly 32/W cycles plus one per stalled cycle: 32, 8 or 4 unstalled cycles.
- The unstalled last beat in cycle m gives `o_ibus_cyc`=1 in m+1. That cycle sees the PC already updated by `serv_ctrl` at the edge ending m.
- Minimum instruction period (ack and go each on their first opportunity) = 32/W + 2 cycles.
- `o_pc_en` is never high outside RUN. Exactly 32/W `pc_en` pulses occur per RUN.

## Test plan
- **Reset and first fetch.** Stimulus: W=1, hold `i_rst_n`=0 for 3 cycles, then release. Required: all outputs 0 during reset and in the IDLE cycle; `o_ibus_cyc`=1 in the 2nd cycle after release.
- **Full RUN, W=1.** Stimulus: ack, then go. Required:
  - 32 consecutive `pc_en` cycles.
  - `cnt0` on beat 0, `cnt1`/`cnt2`/`cnt3` on beats 1/2/3, `cnt03` on beats 0–3, `cnt8` on beat 8, `cnt12to31` on beats 12–31, `cnt_done` on beat 31.
  - `o_ibus_cyc`=1 on the following cycle.
- **W=4 and W=8 builds.** Required:
  - W=4: 8 beats; `cnt03` only at p=0; `cnt8` at p=8; `cnt12to31` at p=12..28; `cnt_done` at p=28.
  - W=8: 4 beats; `cnt12to31` at p=16,24; `cnt_done` at p=24.
- **Stalls.** Stimulus: W=1, `i_stall`=1 for 3 cycles at p=5 and for 2 cycles at p=31. Required:
  - p holds during each stall; `pc_en`=0 during the stalls.
  - RUN lasts 37 cycles in total.
  - FETCH is entered only after the unstalled beat 31.
- **Handshake edges.** Stimulus: ack delayed 5 cycles; ack asserted in IDLE and in WAIT; go held low 4 cycles. Required: `o_ibus_cyc` stays high until ack; acks in IDLE/WAIT are ignored; RUN starts the cycle after go.
- **Reset mid-RUN.** Stimulus: `i_rst_n`=0 at p=17. Required: next cycle is IDLE with all outputs 0; a fresh fetch follows, starting from p=0.
